// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential prefetch into a 2-entry buffer,
// flushed and redirected on taken branch/jump from the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        branch_notequal,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs1_val
);

    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic [1:0]  occ;
    logic        pend;
    logic        discard;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [31:0] pc0;
    logic [31:0] pc1;

    logic        accept;
    logic        resp;
    logic        push;
    logic        pend_after;
    logic        taken;
    logic [31:0] seq_pc;
    logic [31:0] target;

    assign imem_req    = !rst && !pend && (occ != 2'd2);
    assign imem_addr   = fpc;
    assign instr_valid = (occ != 2'd0);
    assign instr       = instr_valid ? word0 : NOP_INSTR;
    assign instr_pc    = pc0;
    assign accept      = instr_valid && instr_ready;
    assign resp        = imem_rvalid && pend;
    assign push        = resp && !discard;
    assign pend_after  = imem_req || (pend && !imem_rvalid);
    assign seq_pc      = pc0 + 32'd4;

    // Redirect decision for the head being accepted: jump_reg > jump > branch
    always_comb begin
        taken  = 1'b0;
        target = seq_pc;
        if (accept) begin
            if (jump_reg) begin
                taken  = 1'b1;
                target = rs1_val;
            end else if (jump) begin
                taken  = 1'b1;
                target = seq_pc + {{6{imm26[25]}}, imm26};
            end else if (branch) begin
                taken  = (rs1_val == 32'd0) != branch_notequal;
                target = seq_pc + {{16{imm16[15]}}, imm16};
            end
        end
    end

    // Fetch pointer, request tracking and the 2-entry instruction buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc     <= RESET_PC;
            req_pc  <= RESET_PC;
            occ     <= 2'd0;
            pend    <= 1'b0;
            discard <= 1'b0;
            word0   <= NOP_INSTR;
            word1   <= NOP_INSTR;
            pc0     <= RESET_PC;
            pc1     <= RESET_PC;
        end else begin
            if (imem_req) begin
                fpc    <= fpc + 32'd4;
                req_pc <= fpc;
            end
            pend <= pend_after;
            if (taken) begin
                occ     <= 2'd0;
                fpc     <= target;
                discard <= pend_after;
            end else begin
                if (resp) begin
                    discard <= 1'b0;
                end
                unique case ({accept, push})
                    2'b10: begin
                        word0 <= word1;
                        pc0   <= pc1;
                        occ   <= occ - 2'd1;
                    end
                    2'b01: begin
                        if (occ == 2'd0) begin
                            word0 <= imem_rdata;
                            pc0   <= req_pc;
                        end else begin
                            word1 <= imem_rdata;
                            pc1   <= req_pc;
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            word0 <= imem_rdata;
                            pc0   <= req_pc;
                        end else begin
                            word0 <= word1;
                            pc0   <= pc1;
                            word1 <= imem_rdata;
                            pc1   <= req_pc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
